uart_rx_fifo: RTL and testbench

// - Receive buffer directly downstream of the UART receiver. Detects each completed frame
//   (rx_done), captures data_out/frame_error/parity_error once they have settled, and stores

---
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind a UART receiver: syncs rx_done, waits for the data to settle, stores
// frames in a show-ahead FIFO. Optional macro UART_RX_FIFO_ERR_DROP_EN drops errored frames.
module uart_rx_fifo #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     rx_frame_err,
    input  logic                     rx_parity_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_frame_err,
    output logic                     rd_parity_err,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     overrun_clr
`ifdef UART_RX_FIFO_ERR_DROP_EN
    ,
    output logic [15:0]              err_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite
    } state_e;

    logic          sync1_q, sync2_q, edge_q;
    logic          done_rise;
    state_e        state_q;
    logic [3:0]    cnt_q;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q, overrun_q;
    logic          push, pop, wr_en, overrun_set;
    logic [9:0]    head;

    // Flops reset to 1 so a receiver already signalling done at reset release is not captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= rx_done;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign done_rise = sync2_q & ~edge_q;

    // Capture FSM: edges arriving outside StIdle are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (done_rise) begin
                        state_q <= StWait;
                        cnt_q   <= SETTLE_INIT;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StWrite;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWrite: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic err_frame;
    assign err_frame = rx_frame_err | rx_parity_err;
    assign push      = (state_q == StWrite) & ~err_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_drop_cnt <= '0;
        end else if ((state_q == StWrite) && err_frame && (err_drop_cnt != 16'hFFFF)) begin
            err_drop_cnt <= err_drop_cnt + 16'd1;
        end
    end
`else
    assign push = (state_q == StWrite);
`endif

    assign pop         = rd_valid & rd_ready;
    assign wr_en       = push & (~full_q | pop);
    assign overrun_set = push & full_q & ~pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {rx_parity_err, rx_frame_err, rx_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= (level_d == LEVEL_FULL);
            empty_q <= (level_d == '0);
            // A lost frame outranks a simultaneous clear.
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_valid      = ~empty_q;
    assign rd_data       = rd_valid ? head[7:0] : 8'h00;
    assign rd_frame_err  = rd_valid & head[8];
    assign rd_parity_err = rd_valid & head[9];
    assign full          = full_q;
    assign empty         = empty_q;
    assign level         = level_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, SETTLE_CYCLES=4).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_parity_err;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overrun;
    logic       overrun_clr;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic [15:0] err_drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];
    int         rcount;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH         (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_done       (rx_done),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
`ifdef UART_RX_FIFO_ERR_DROP_EN
        ,
        .err_drop_cnt  (err_drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic fe, input logic pe);
        @(negedge clk);
        rx_data       = d;
        rx_frame_err  = fe;
        rx_parity_err = pe;
        rx_done       = 1'b1;
        repeat (10) @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        rx_done       = 1'b0;
        rx_data       = 8'h00;
        rx_frame_err  = 1'b0;
        rx_parity_err = 1'b0;
        rd_ready      = 1'b0;
        overrun_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency: rd_valid rises on the 8th clock edge after rx_done.
        rx_data = 8'hA5;
        rx_done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) check("lat_early", 32'(rd_valid), 32'd0);
            if (i == 8) check("lat_valid", 32'(rd_valid), 32'd1);
        end
        check("lat_data", 32'(rd_data), 32'hA5);
        check("lat_level", 32'(level), 32'd1);
        check("lat_errs", 32'({rd_parity_err, rd_frame_err}), 32'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check("pop_empty", 32'(empty), 32'd1);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check("ready_on_empty", 32'(level), 32'd0);

        // Fill, overflow, drain.
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        check("fill_overrun", 32'(overrun), 32'd0);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(rd_data), 32'(i));
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Full FIFO with pop coincident with the 17th push.
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0);
        @(negedge clk);
        rx_data = 8'hFF;
        rx_done = 1'b1;
        repeat (7) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check("pp_level", 32'(level), 32'd16);
        check("pp_full", 32'(full), 32'd1);
        check("pp_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("pp_drain", 32'(rd_data), 32'(8'h10 + i));
            @(negedge clk);
        end
        check("pp_last", 32'(rd_data), 32'hFF);
        @(negedge clk);
        rd_ready = 1'b0;
        check("pp_empty", 32'(empty), 32'd1);

        // Errored frames.
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
        check("ferr_level", 32'(level), 32'd0);
        check("ferr_cnt", 32'(err_drop_cnt), 32'd1);
        check("ferr_overrun", 32'(overrun), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("perr_cnt", 32'(err_drop_cnt), 32'd2);
        check("perr_level", 32'(level), 32'd0);
`else
        check("ferr_valid", 32'(rd_valid), 32'd1);
        check("ferr_data", 32'(rd_data), 32'h3C);
        check("ferr_flag", 32'(rd_frame_err), 32'd1);
        check("ferr_pflag", 32'(rd_parity_err), 32'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("perr_data", 32'(rd_data), 32'h5A);
        check("perr_flags", 32'({rd_parity_err, rd_frame_err}), 32'b10);
`endif

        // Reset during WAIT with entries stored, rx_done held through release.
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'(8'h41 + i), 1'b0, 1'b0);
        check("mid_level3", 32'(level), 32'd3);
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_no_cap", 32'(level), 32'd0);
        check("held_empty", 32'(empty), 32'd1);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h66, 1'b0, 1'b0);
        check("after_level", 32'(level), 32'd1);
        check("after_data", 32'(rd_data), 32'h66);

        // Backpressure with random rd_ready across 40 frames.
        do_reset();
        rcount = 0;
        fork
            begin
                logic [7:0] d;
                for (int i = 0; i < 40; i++) begin
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    send_frame(d, 1'b0, 1'b0);
                end
            end
            begin
                logic       stalled;
                logic [7:0] held;
                logic       rdy;
                stalled = 1'b0;
                held    = 8'h00;
                for (int cyc = 0; cyc < 3000 && rcount < 40; cyc++) begin
                    @(negedge clk);
                    if (stalled) check("bp_stall_hold", 32'(rd_data), 32'(held));
                    rdy      = 1'($urandom_range(0, 1));
                    rd_ready = rdy;
                    if (rd_valid && rdy) begin
                        check("bp_data", 32'(rd_data), 32'(exp_q[rcount]));
                        rcount++;
                        stalled = 1'b0;
                    end else begin
                        stalled = rd_valid;
                        held    = rd_data;
                    end
                end
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        check("bp_count", 32'(rcount), 32'd40);
        check("bp_empty", 32'(empty), 32'd1);
        check("bp_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
